// File: rtl/rv64_mem_defs.sv
// Shared encodings and helpers for the unified-memory arbiter of the rv64 multicycle core.
package rv64_mem_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam int unsigned MEM_LAT_DEFAULT = 1;
   localparam logic [3:0]  IF_LEN          = 4'd4;

   // A fetch returns the 32-bit half of the doubleword selected by address bit 2.
   function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] data);
      return hi ? data[63:32] : data[31:0];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select between instruction fetch and load/store.
module rr_arb2
   import rv64_mem_defs::*;
(
   input  logic   req_if,
   input  logic   req_ls,
   input  owner_t last_owner,
   output logic   any,
   output owner_t owner
);

   // On a tie the requester that did not win last time gets the memory.
   always_comb begin
      any   = 1'b0;
      owner = OWN_LS;
      if (req_if && req_ls) begin
         any   = 1'b1;
         owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
      end else if (req_if) begin
         any   = 1'b1;
         owner = OWN_IF;
      end else if (req_ls) begin
         any   = 1'b1;
         owner = OWN_LS;
      end else begin
         any   = 1'b0;
         owner = OWN_LS;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and LS accesses onto one single-ported memory, one transaction at a time.
module mem_arbiter
   import rv64_mem_defs::*;
#(
   parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
   parameter int unsigned MEM_AW  = 11
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              if_req,
   input  logic [63:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [63:0]       ls_addr,
   input  logic [63:0]       ls_wdata,
   input  logic [3:0]        ls_len,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [63:0]       ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [3:0]        mem_len,
   input  logic [63:0]       mem_rdata
);

   localparam logic [7:0] CNT_INIT = 8'(MEM_LAT - 1);

   state_t     state_r;
   owner_t     owner_r;
   owner_t     last_owner_r;
   logic       we_r;
   logic [7:0] cnt_r;
   logic       if_elig_s;
   logic       any_s;
   owner_t     sel_s;
   logic       unused_s;

   assign if_elig_s = if_req & ~halt;
   // Address bits above the memory window are deliberately dropped.
   assign unused_s  = &{1'b0, if_addr[63:MEM_AW], ls_addr[63:MEM_AW]};

   rr_arb2 u_rr_arb2 (
      .req_if     (if_elig_s),
      .req_ls     (ls_req),
      .last_owner (last_owner_r),
      .any        (any_s),
      .owner      (sel_s)
   );

   // Transaction FSM; strobes are set on entry to the state that shows them so every output is a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         owner_r      <= OWN_IF;
         last_owner_r <= OWN_IF;
         we_r         <= 1'b0;
         cnt_r        <= 8'd0;
         if_gnt       <= 1'b0;
         if_rvalid    <= 1'b0;
         if_rdata     <= 32'd0;
         ls_gnt       <= 1'b0;
         ls_rvalid    <= 1'b0;
         ls_rdata     <= 64'd0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {MEM_AW{1'b0}};
         mem_wdata    <= 64'd0;
         mem_len      <= 4'd0;
      end else begin
         if_gnt    <= 1'b0;
         ls_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  owner_r <= sel_s;
                  state_r <= ISSUE;
                  mem_en  <= 1'b1;
                  if (sel_s == OWN_LS) begin
                     ls_gnt    <= 1'b1;
                     we_r      <= ls_we;
                     mem_we    <= ls_we;
                     mem_addr  <= ls_addr[MEM_AW-1:0];
                     mem_wdata <= ls_wdata;
                     mem_len   <= ls_len;
                  end else begin
                     if_gnt    <= 1'b1;
                     we_r      <= 1'b0;
                     mem_addr  <= if_addr[MEM_AW-1:0];
                     mem_wdata <= 64'd0;
                     mem_len   <= IF_LEN;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               last_owner_r <= owner_r;
               cnt_r        <= CNT_INIT;
               state_r      <= WAIT;
            end
            WAIT: begin
               if (cnt_r != 8'd0) begin
                  cnt_r <= cnt_r - 8'd1;
               end else begin
                  state_r <= RESP;
                  if (owner_r == OWN_IF) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= fetch_word(mem_addr[2], mem_rdata);
                  end else begin
                     ls_rvalid <= 1'b1;
                     ls_rdata  <= we_r ? 64'd0 : mem_rdata;
                  end
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard of expected responses.
module tb_mem_arbiter;

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [3:0]  len;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      logic        is_ls;
      logic [63:0] data;
      int          cyc;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   sb_t sb_q[$];
   sb_t mon_e;

   // MEM_LAT = 1 instance
   logic        halt, if_req, ls_req, ls_we;
   logic [63:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_len;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
   logic [31:0] if_rdata;
   logic [63:0] ls_rdata, mem_wdata, mem_rdata;
   logic [10:0] mem_addr;
   logic [3:0]  mem_len;

   // MEM_LAT = 4 instance
   logic        b_halt, b_if_req, b_ls_req, b_ls_we;
   logic [63:0] b_if_addr, b_ls_addr, b_ls_wdata;
   logic [3:0]  b_ls_len;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we;
   logic [31:0] b_if_rdata;
   logic [63:0] b_ls_rdata, b_mem_wdata, b_mem_rdata;
   logic [10:0] b_mem_addr;
   logic [3:0]  b_mem_len;

   mem_arbiter #(.MEM_LAT(1), .MEM_AW(11)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_len(ls_len),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_len(mem_len), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.MEM_LAT(4), .MEM_AW(11)) dut4 (
      .clk(clk), .rst(rst), .halt(b_halt),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_len(b_ls_len),
      .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_len(b_mem_len), .mem_rdata(b_mem_rdata)
   );

   // Memory model for the latency-1 instance: junk on the bus except in the valid cycle.
   logic [63:0] mem [0:255];
   logic        rd_v = 1'b0;
   logic [63:0] rd_d = 64'd0;
   always @(posedge clk) begin
      rd_v <= mem_en && !mem_we;
      rd_d <= mem[mem_addr[10:3]];
      if (mem_en && mem_we) mem[mem_addr[10:3]] <= mem_wdata;
   end
   assign mem_rdata = rd_v ? rd_d : 64'hBADC_0FFE_E0DD_F00D;

   // Latency-4 memory: decoy data one cycle early, real data exactly 4 cycles after mem_en.
   logic [4:1] b_pipe = 4'd0;
   always @(posedge clk) b_pipe <= {b_pipe[3:1], b_mem_en};
   assign b_mem_rdata = b_pipe[4] ? 64'h0123_4567_89AB_CDEF :
                        (b_pipe[3] ? 64'hFEDC_BA98_7654_3210 : 64'd0);

   task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%h, required 0x%h", nm, act, req);
      end
   endtask

   // Response monitor: every rvalid must match the oldest expected response.
   always @(negedge clk) begin
      if (rst && (if_rvalid || ls_rvalid)) begin
         if (sb_q.size() == 0) begin
            check64("unexpected_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check64("rv_owner", 64'({if_rvalid, ls_rvalid}), mon_e.is_ls ? 64'd1 : 64'd2);
            check64("rv_data", mon_e.is_ls ? ls_rdata : {32'd0, if_rdata}, mon_e.data);
            check64("rv_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic drain(input string nm);
      for (int c = 0; c < 30 && sb_q.size() != 0; c++) @(negedge clk);
      check64({nm, "_drain"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      bit          got;
      logic [63:0] a;
      got = 1'b0;
      a   = v.addr;
      if (v.is_ls) begin
         ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_len = v.len; ls_req = 1'b1;
      end else begin
         if_addr = v.addr; if_req = 1'b1;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if_gnt || ls_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      check64({nm, "_gnt"}, 64'({if_gnt, ls_gnt}), v.is_ls ? 64'd1 : 64'd2);
      if (got) begin
         check64({nm, "_en_we"}, 64'({mem_en, mem_we}), 64'({1'b1, v.we}));
         check64({nm, "_addr"}, 64'(mem_addr), 64'(a[10:0]));
         check64({nm, "_len"}, 64'(mem_len), v.is_ls ? 64'(v.len) : 64'd4);
         if (v.we) check64({nm, "_wdata"}, mem_wdata, v.wdata);
         sb_q.push_back('{v.is_ls, v.exp, cyc + 2});
      end
      drain(nm);
   endtask

   vec_t vecs[8];
   int   n, prev, cnt, g;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 64'd0;
      mem[0] = 64'h1111_2222_3333_4444;
      mem[1] = 64'h5555_6666_7777_8888;
      mem[3] = 64'hA5A5_0003_C3C3_0003;

      vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'd0, 4'd4, 64'h1111_2222};
      vecs[1] = '{1'b0, 1'b0, 64'h0000_0000_0000_0000, 64'd0, 4'd4, 64'h3333_4444};
      vecs[2] = '{1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 4'd8, 64'd0};
      vecs[3] = '{1'b1, 1'b0, 64'h10, 64'd0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D};
      vecs[4] = '{1'b1, 1'b0, 64'hFFFF_FFFF_0000_0018, 64'd0, 4'd8, 64'hA5A5_0003_C3C3_0003};
      vecs[5] = '{1'b0, 1'b0, 64'h1C, 64'd0, 4'd4, 64'hA5A5_0003};
      vecs[6] = '{1'b1, 1'b1, 64'h28, 64'h1234, 4'd2, 64'd0};
      vecs[7] = '{1'b1, 1'b0, 64'h28, 64'd0, 4'd4, 64'h1234};

      rst = 1'b0; halt = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = 64'd0; ls_addr = 64'd0; ls_wdata = 64'd0; ls_len = 4'd0;
      b_halt = 1'b0; b_if_req = 1'b0; b_ls_req = 1'b0; b_ls_we = 1'b0;
      b_if_addr = 64'd0; b_ls_addr = 64'd0; b_ls_wdata = 64'd0; b_ls_len = 4'd0;

      repeat (2) @(negedge clk);
      check64("rst_strobes", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we}), 64'd0);
      check64("rst_if_rdata", 64'(if_rdata), 64'd0);
      check64("rst_ls_rdata", ls_rdata, 64'd0);
      check64("rst_mem_bus", 64'({mem_addr, mem_len}) | mem_wdata, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Tie straight after reset, both requests held: LS, IF, LS, IF, each MEM_LAT+3 apart.
      if_addr = 64'h8; ls_addr = 64'h18; ls_we = 1'b0; ls_len = 4'd8;
      if_req = 1'b1; ls_req = 1'b1;
      n = 0; prev = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (if_gnt || ls_gnt) begin
            check64($sformatf("tie_order%0d", n), 64'({if_gnt, ls_gnt}), (n % 2 == 0) ? 64'd1 : 64'd2);
            if (n > 0) check64($sformatf("tie_gap%0d", n), 64'(cyc - prev), 64'd4);
            prev = cyc;
            sb_q.push_back('{ls_gnt, ls_gnt ? 64'hA5A5_0003_C3C3_0003 : 64'h7777_8888, cyc + 2});
            n++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      check64("tie_count", 64'(n), 64'd4);
      drain("tie");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // halt blocks IF selection only; an IF already granted still completes.
      halt = 1'b1; if_addr = 64'd0; if_req = 1'b1;
      ls_addr = 64'd0; ls_we = 1'b0; ls_len = 4'd8; ls_req = 1'b1;
      for (int c = 0; c < 20 && !(if_gnt || ls_gnt); c++) @(negedge clk);
      check64("halt_ls_gnt", 64'({if_gnt, ls_gnt}), 64'd1);
      if (ls_gnt) sb_q.push_back('{1'b1, 64'h1111_2222_3333_4444, cyc + 2});
      ls_req = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (if_gnt) cnt++;
      end
      check64("halt_blocks_if", 64'(cnt), 64'd0);
      halt = 1'b0;
      @(negedge clk);
      check64("halt_release_gnt", 64'({if_gnt, ls_gnt}), 64'd2);
      if (if_gnt) sb_q.push_back('{1'b0, 64'h3333_4444, cyc + 2});
      if_req = 1'b0;
      halt = 1'b1;
      drain("halt");
      halt = 1'b0;

      // Latency-4 load: decoy word one cycle early must not be captured.
      b_ls_addr = 64'h20; b_ls_we = 1'b0; b_ls_len = 4'd8; b_ls_req = 1'b1;
      for (int c = 0; c < 20 && !b_ls_gnt; c++) @(negedge clk);
      g = cyc;
      b_ls_req = 1'b0;
      check64("lat4_gnt_en", 64'({b_ls_gnt, b_mem_en}), 64'd3);
      check64("lat4_addr", 64'(b_mem_addr), 64'h20);
      for (int c = 0; c < 20 && !b_ls_rvalid; c++) @(negedge clk);
      check64("lat4_rvalid", 64'(b_ls_rvalid), 64'd1);
      check64("lat4_latency", 64'(cyc - g), 64'd5);
      check64("lat4_rdata", b_ls_rdata, 64'h0123_4567_89AB_CDEF);

      // Reset pulse while waiting on memory: everything clears at once, nothing trails out.
      if_addr = 64'h8; if_req = 1'b1;
      for (int c = 0; c < 20 && !if_gnt; c++) @(negedge clk);
      if_req = 1'b0;
      check64("rstw_gnt", 64'(if_gnt), 64'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check64("rstw_strobes", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_len}), 64'd0);
      check64("rstw_mem_addr", 64'(mem_addr), 64'd0);
      check64("rstw_if_rdata", 64'(if_rdata), 64'd0);
      check64("rstw_ls_rdata", ls_rdata, 64'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (if_gnt || ls_gnt || if_rvalid || ls_rvalid) cnt++;
      end
      check64("rstw_quiet", 64'(cnt), 64'd0);
      run_vec(vecs[0], "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between pc_gen/idu-side requesters and the memory macro, and replaces the separate instr_mem/data_mem split for the multicycle core.
- Serialises accesses with one outstanding transaction, round-robin arbitration and a fixed memory read latency.
- Blocks instruction fetch while the core is halted on ebreak.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..255.
- MEM_AW, 11, number of address bits driven to memory; the low MEM_AW bits of the 64-bit request address are used.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- halt  in  1  ebreak seen; IF requests are not granted while high.
- if_req  in  1  fetch request, level, held until if_gnt.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_rvalid  out  1  one-cycle fetch data valid.
- if_rdata  out  32  fetched instruction.
- ls_req  in  1  load/store request, level, held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  64  load/store byte address.
- ls_wdata  in  64  store data.
- ls_len  in  4  byte length, one of 1, 2, 4 or 8.
- ls_gnt  out  1  one-cycle grant pulse to LS.
- ls_rvalid  out  1  one-cycle completion: load data valid, or store acknowledge.
- ls_rdata  out  64  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  memory address.
- mem_wdata  out  64  memory write data.
- mem_len  out  4  memory access length.
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; last_owner = IF, so the first tie goes to LS; cnt = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Eligible requesters are ls_req, and if_req only when halt = 0.
  - With none eligible, stay in IDLE.
  - With one eligible, that requester is the owner.
  - With both eligible, the owner is the one that is not last_owner.
  - On selecting an owner: latch owner, address, we, wdata and len (we = 0 and len = 4 for IF), then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_* driven from the latched values.
  - The owner's gnt = 1.
  - last_owner <= owner; cnt <= MEM_LAT-1; go to WAIT.
- WAIT:
  - While cnt != 0: decrement cnt and stay in WAIT.
  - When cnt == 0: capture mem_rdata (the cycle ISSUE+MEM_LAT) and go to RESP.
  - Stores also pass through WAIT; their captured data is discarded.
- RESP (exactly 1 cycle):
  - The owner's rvalid = 1, then go to IDLE.
  - IF data: if_rdata = latched addr[2] ? captured[63:32] : captured[31:0].
  - LS data: ls_rdata = captured[63:0] for loads, 0 for stores.
  - rdata outputs hold their value until the next RESP of the same requester.
- Latency with MEM_LAT = 1: req sampled in cycle T0, gnt in T1, rvalid in T3. Minimum request-to-request spacing is MEM_LAT+3 cycles.
- Requests are sampled only in IDLE. A request raised during ISSUE/WAIT/RESP waits. Dropping req before gnt is a protocol violation; the bench does not drive it.
- halt rising during an IF transaction does not abort it; it completes with if_rvalid. halt only gates new IF selection.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, the transaction is dropped, and no rvalid or gnt is produced after reset release.
- Address bits above MEM_AW are ignored; there is no error.
- Alignment checking is out of scope.
- cnt is 8 bits wide; MEM_LAT = 1 gives zero WAIT cycles of decrement.

Decomposition:
- Shared header/package rv64_mem_defs holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - owner encoding (OWN_IF=1'b0, OWN_LS=1'b1);
  - the default MEM_LAT.
- One sub-module, rr_arb2: a combinational 2-input round-robin select from (req_if, req_ls, last_owner) to (any, owner).
- The FSM, latches and counter stay in mem_arbiter.

Test Plan:
- IF only, MEM_LAT=1: if_req=1, if_addr=0x80000004, mem returns 0x11112222_33334444 -> mem_en and mem_addr=0x004 in T1, if_gnt in T1, if_rvalid in T3, if_rdata=0x11112222.
- Tie after reset: if_req and ls_req both high in the same IDLE cycle -> LS granted first, then IF. With both held, grants strictly alternate LS, IF, LS, IF over 4 transactions.
- Store: ls_we=1, ls_addr=0x10, ls_wdata=0xDEADBEEF_CAFEF00D, ls_len=8 -> mem_en=1, mem_we=1, mem_addr=0x010, mem_len=8, mem_wdata matches; ls_rvalid 2 cycles after gnt; ls_rdata=0.
- MEM_LAT=4 load: ls_req for 0x20, memory returns 0x0123456789ABCDEF exactly 4 cycles after mem_en -> ls_rvalid 5 cycles after ls_gnt with ls_rdata=0x0123456789ABCDEF. Data presented at 3 cycles is not captured.
- halt=1 with if_req and ls_req high -> only LS is granted; if_gnt stays 0 until halt=0, then IF is granted on the next IDLE.
- Reset pulse during WAIT -> all outputs 0 asynchronously; no if_rvalid/ls_rvalid afterward; a fresh request after release completes normally.
